// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-read-port register file with busy-bit scoreboard; optional write bypass via REGFILE_BYPASS_EN
module regfile_mp #(
    parameter int DW       = 32,
    parameter int AW       = 5,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 2**AW - 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*DW-1:0]   rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [DW-1:0]       wr_data,
    input  logic                rsv_en,
    input  logic [AW-1:0]       rsv_addr,
    output logic [AW:0]         busy_cnt
);

    localparam int            DEPTH = 2**AW;
    localparam logic [AW-1:0] ZA    = AW'(ZERO_REG);

    logic [DW-1:0]    mem_q [DEPTH];
    logic [DW-1:0]    mem_d [DEPTH];
    logic [DEPTH-1:0] busy_q, busy_d;
    logic [AW:0]      busy_cnt_q, busy_cnt_d;

    logic wr_ok, rsv_ok, cnt_inc, cnt_dec;

    assign wr_ok  = wr_en  && (wr_addr  != ZA);
    assign rsv_ok = rsv_en && (rsv_addr != ZA);

    // Next state: write data, then clear-on-write, then set-on-reserve so a same-cycle reserve wins
    always_comb begin
        mem_d  = mem_q;
        busy_d = busy_q;
        if (wr_ok) begin
            mem_d[wr_addr]  = wr_data;
            busy_d[wr_addr] = 1'b0;
        end
        if (rsv_ok) begin
            busy_d[rsv_addr] = 1'b1;
        end
    end

    // Incremental busy count: only real 0->1 and 1->0 transitions move it
    always_comb begin
        cnt_inc    = rsv_ok && !busy_q[rsv_addr];
        cnt_dec    = wr_ok && busy_q[wr_addr] && !(rsv_ok && (rsv_addr == wr_addr));
        busy_cnt_d = busy_cnt_q + {{AW{1'b0}}, cnt_inc} - {{AW{1'b0}}, cnt_dec};
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            mem_q      <= mem_d;
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign busy_cnt = busy_cnt_q;

    for (genvar g = 0; g < NRD; g++) begin : g_rd
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic          b;

        assign a = rd_addr[g*AW +: AW];

        // Combinational read port; the zero register always reads idle zero
        always_comb begin
            d = '0;
            b = 1'b0;
            if (a != ZA) begin
                d = mem_q[a];
                b = busy_q[a];
`ifdef REGFILE_BYPASS_EN
                if (wr_en && (wr_addr == a)) begin
                    d = wr_data;
                    b = rsv_en && (rsv_addr == a);
                end
`endif
            end
        end

        assign rd_data[g*DW +: DW] = d;
        assign rd_busy[g]          = b;
    end

endmodule
